// File: rtl/img_gen_pkg.sv
// Shared types and constants for the image stream generator.
package img_gen_pkg;

    localparam int unsigned LFSR_W  = 32;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned NUM_W   = 32;

    localparam logic [LFSR_W-1:0] IMG_GEN_LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        MODE_CONST   = 2'd0,
        MODE_HRAMP   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_LFSR    = 2'd3
    } img_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } img_state_e;

    // Right-shifting Galois step: feedback taps applied when the bit shifted out is 1.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ IMG_GEN_LFSR_POLY) : (s >> 1);
    endfunction

    // An all-zero state would lock up, so a zero seed starts from 1.
    function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [31:0] seed);
        return (seed == 32'd0) ? LFSR_W'(1) : LFSR_W'(seed);
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] sh);
        return (v << sh) | (v >> (6'd32 - 6'(sh)));
    endfunction

endpackage

// File: rtl/img_gen_pattern.sv
// Combinational pixel formatter: builds one CHANNELS-wide word from the pixel coordinates.
// Mode 3 reads the LFSR state only when IMG_GEN_LFSR_EN is defined; otherwise it is a ramp.
module img_gen_pattern
    import img_gen_pkg::*;
#(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned DIM_W    = 12
) (
    input  logic [DIM_W-1:0]           x,
    input  logic [DIM_W-1:0]           y,
    input  img_mode_e                  mode,
    input  logic [31:0]                seed,
`ifdef IMG_GEN_LFSR_EN
    input  logic [LFSR_W-1:0]          lfsr,
`endif
    output logic [DWIDTH*CHANNELS-1:0] word
);

    // 8x8 checker squares: colour flips whenever bit 3 of x or y flips.
    logic checker_on;
    assign checker_on = ((x ^ y) & DIM_W'(8)) != '0;

    always_comb begin
        word = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            case (mode)
                MODE_CONST:   word[c*DWIDTH +: DWIDTH] = DWIDTH'(seed);
                MODE_CHECKER: word[c*DWIDTH +: DWIDTH] = {DWIDTH{checker_on}};
`ifdef IMG_GEN_LFSR_EN
                MODE_LFSR:    word[c*DWIDTH +: DWIDTH] = DWIDTH'(rotl32(lfsr, 5'(c * 8)));
`endif
                default:      word[c*DWIDTH +: DWIDTH] = DWIDTH'(32'(x) + 32'(c));
            endcase
        end
    end

endmodule

// File: rtl/image_stream_gen.sv
// Self-contained test-pattern source writing framed pixel runs into a downstream FIFO.
// Optional LFSR pattern (mode 3) is built only when IMG_GEN_LFSR_EN is defined.
module image_stream_gen
    import img_gen_pkg::*;
#(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned DIM_W    = 12
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [DIM_W-1:0]           cfg_width,
    input  logic [DIM_W-1:0]           cfg_height,
    input  logic [FRAME_W-1:0]         cfg_frames,
    input  logic [1:0]                 cfg_mode,
    input  logic [31:0]                cfg_seed,
    input  logic                       fifo_full,
    output logic [DWIDTH*CHANNELS-1:0] fifo_data,
    output logic                       fifo_wrreq,
    output logic                       fifo_sop,
    output logic                       fifo_eop,
    output logic [NUM_W-1:0]           num_data,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned WORD_W = DWIDTH * CHANNELS;

    img_state_e          state_q, state_d;
    img_mode_e           mode_q, mode_d;
    logic [DIM_W-1:0]    x_q, x_d, y_q, y_d;
    logic [DIM_W-1:0]    width_q, width_d, height_q, height_d;
    logic [FRAME_W-1:0]  frame_q, frame_d, frames_q, frames_d;
    logic [31:0]         seed_q, seed_d;
    logic                last_q, last_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                wrreq_q, wrreq_d, sop_q, sop_d, eop_q, eop_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [NUM_W-1:0]    num_q, num_d;
`ifdef IMG_GEN_LFSR_EN
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
`endif

    logic [WORD_W-1:0]   pix;
    logic                x_end, y_end, frame_last;

    assign x_end      = (x_q == DIM_W'(width_q - DIM_W'(1)));
    assign y_end      = (y_q == DIM_W'(height_q - DIM_W'(1)));
    assign frame_last = (frames_q != '0) && (frame_q == FRAME_W'(frames_q - FRAME_W'(1)));

    img_gen_pattern #(
        .DWIDTH   (DWIDTH),
        .CHANNELS (CHANNELS),
        .DIM_W    (DIM_W)
    ) u_pattern (
        .x    (x_q),
        .y    (y_q),
        .mode (mode_q),
        .seed (seed_q),
`ifdef IMG_GEN_LFSR_EN
        .lfsr (lfsr_q),
`endif
        .word (pix)
    );

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        x_d      = x_q;
        y_d      = y_q;
        width_d  = width_q;
        height_d = height_q;
        frame_d  = frame_q;
        frames_d = frames_q;
        seed_d   = seed_q;
        last_d   = last_q;
        data_d   = data_q;
        num_d    = num_q;
        wrreq_d  = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
`ifdef IMG_GEN_LFSR_EN
        lfsr_d   = lfsr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    frames_d = cfg_frames;
                    mode_d   = img_mode_e'(cfg_mode);
                    seed_d   = cfg_seed;
                    x_d      = '0;
                    y_d      = '0;
                    frame_d  = '0;
                    last_d   = 1'b0;
                    num_d    = NUM_W'(32'(cfg_width) * 32'(cfg_height));
`ifdef IMG_GEN_LFSR_EN
                    lfsr_d   = lfsr_seed(cfg_seed);
`endif
                    state_d  = ((cfg_width != '0) && (cfg_height != '0)) ? ST_RUN : ST_DONE;
                end
            end

            // last_q holds RUN one extra cycle so done lands after the final write.
            ST_RUN: begin
                if (abort || last_q) begin
                    state_d = ST_DONE;
                end else if (!fifo_full) begin
                    wrreq_d = 1'b1;
                    data_d  = pix;
                    sop_d   = (x_q == '0) && (y_q == '0);
                    eop_d   = x_end && y_end;
`ifdef IMG_GEN_LFSR_EN
                    lfsr_d  = lfsr_step(lfsr_q);
`endif
                    if (x_end) begin
                        x_d = '0;
                        if (y_end) begin
                            y_d     = '0;
                            frame_d = frame_q + FRAME_W'(1);
                            last_d  = frame_last;
                        end else begin
                            y_d = y_q + DIM_W'(1);
                        end
                    end else begin
                        x_d = x_q + DIM_W'(1);
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_CONST;
            x_q      <= '0;
            y_q      <= '0;
            width_q  <= '0;
            height_q <= '0;
            frame_q  <= '0;
            frames_q <= '0;
            seed_q   <= '0;
            last_q   <= 1'b0;
            data_q   <= '0;
            num_q    <= '0;
            wrreq_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            x_q      <= x_d;
            y_q      <= y_d;
            width_q  <= width_d;
            height_q <= height_d;
            frame_q  <= frame_d;
            frames_q <= frames_d;
            seed_q   <= seed_d;
            last_q   <= last_d;
            data_q   <= data_d;
            num_q    <= num_d;
            wrreq_q  <= wrreq_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef IMG_GEN_LFSR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_W'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign fifo_data  = data_q;
    assign fifo_wrreq = wrreq_q;
    assign fifo_sop   = sop_q;
    assign fifo_eop   = eop_q;
    assign num_data   = num_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_image_stream_gen.sv
// Self-checking bench for image_stream_gen: table-driven runs against a frame-index reference model.
module tb_image_stream_gen;

    typedef struct {
        int          w;
        int          h;
        int          frames;
        int          mode;
        logic [31:0] seed;
        int          pct;
        int          exp_num;
        int          exp_writes;
    } vec_t;

    typedef struct {
        logic [23:0] d;
        logic        sop;
        logic        eop;
        int          cyc;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        fifo_full = 1'b0;
    logic [11:0] cfg_width = '0;
    logic [11:0] cfg_height = '0;
    logic [15:0] cfg_frames = '0;
    logic [1:0]  cfg_mode = '0;
    logic [31:0] cfg_seed = '0;
    logic [23:0] fifo_data;
    logic        fifo_wrreq, fifo_sop, fifo_eop, busy, done;
    logic [31:0] num_data;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    wr_t  wq[$];
    int   dq[$];
    wr_t  rec;
    logic last_full = 1'b0;
    vec_t vt[9];
    int   stall_cyc[8] = '{2, 3, 7, 8, 9, 10, 11, 12};

    image_stream_gen #(.DWIDTH(8), .CHANNELS(3), .DIM_W(12)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_frames (cfg_frames),
        .cfg_mode   (cfg_mode),
        .cfg_seed   (cfg_seed),
        .fifo_full  (fifo_full),
        .fifo_data  (fifo_data),
        .fifo_wrreq (fifo_wrreq),
        .fifo_sop   (fifo_sop),
        .fifo_eop   (fifo_eop),
        .num_data   (num_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] galois(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Expected word from the pattern rules, one 8-bit channel at a time.
    function automatic logic [23:0] model_word(input int mode, input int x, input int y,
                                               input logic [31:0] seed, input logic [31:0] lf);
        logic [23:0] w;
        logic [7:0]  ch;
`ifdef IMG_GEN_LFSR_EN
        logic [63:0] dbl;
`endif
        w = '0;
        for (int c = 0; c < 3; c++) begin
            case (mode)
                0: ch = seed[7:0];
                2: ch = (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
`ifdef IMG_GEN_LFSR_EN
                3: begin
                    dbl = {lf, lf};
                    ch  = dbl[32 - 8*c +: 8];
                end
`endif
                default: ch = 8'(x + c);
            endcase
            w[c*8 +: 8] = ch;
        end
        return w;
    endfunction

    // Write/done monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (fifo_wrreq) begin
                rec.d   = fifo_data;
                rec.sop = fifo_sop;
                rec.eop = fifo_eop;
                rec.cyc = cyc;
                wq.push_back(rec);
                chk("write_while_full", 64'(last_full), 64'(0));
            end
            if (fifo_sop || fifo_eop)
                chk("marker_unqualified", 64'({fifo_sop, fifo_eop} & {2{~fifo_wrreq}}), 64'(0));
            if (done) begin
                dq.push_back(cyc);
                chk("busy_at_done", 64'(busy), 64'(0));
            end
        end
        last_full = fifo_full;
    end

    task automatic run_cfg(input vec_t v, input int fstart, input int flen, input int abort_at,
                           output int s, output int acyc);
        bit seen;
        wq.delete();
        dq.delete();
        acyc = -1;
        seen = 1'b0;
        @(posedge clock); #1;
        s          = cyc;
        cfg_width  = 12'(v.w);
        cfg_height = 12'(v.h);
        cfg_frames = 16'(v.frames);
        cfg_mode   = 2'(v.mode);
        cfg_seed   = v.seed;
        start      = 1'b1;
        abort      = 1'b0;
        fifo_full  = 1'b0;
        for (int k = 1; k < 6000; k++) begin
            @(posedge clock); #1;
            start      = busy && ($urandom_range(0, 7) == 0);
            cfg_width  = 12'($urandom);
            cfg_height = 12'($urandom);
            cfg_frames = 16'($urandom);
            cfg_mode   = 2'($urandom);
            cfg_seed   = $urandom;
            abort      = 1'b0;
            if (abort_at > 0 && acyc < 0 && wq.size() == abort_at - 1) begin
                abort = 1'b1;
                acyc  = cyc;
            end
            fifo_full = (k >= fstart && k < fstart + flen) || ($urandom_range(0, 99) < v.pct);
            if (dq.size() > 0 && cyc >= dq[0] + 2) begin
                seen = 1'b1;
                break;
            end
        end
        start     = 1'b0;
        abort     = 1'b0;
        fifo_full = 1'b0;
        chk("run_timeout", 64'(seen), 64'(1));
    endtask

    task automatic verify(input vec_t v, input int s, input int acyc, input int n_exp, input bit consec);
        logic [31:0] lf;
        int area, p, exp_done;
        chk("num_data", 64'(num_data), 64'(v.exp_num));
        chk("write_count", 64'(wq.size()), 64'(n_exp));
        chk("done_count", 64'(dq.size()), 64'(1));
        if (acyc >= 0)            exp_done = acyc + 1;
        else if (n_exp == 0)      exp_done = s + 1;
        else if (consec)          exp_done = s + 2 + n_exp;
        else if (wq.size() > 0)   exp_done = wq[wq.size()-1].cyc + 1;
        else                      exp_done = -1;
        if (dq.size() > 0) chk("done_cycle", 64'(dq[0]), 64'(exp_done));
        lf   = (v.seed == 32'd0) ? 32'd1 : v.seed;
        area = v.w * v.h;
        for (int n = 0; n < wq.size() && n < n_exp; n++) begin
            p = n % area;
            chk($sformatf("data[%0d]", n), 64'(wq[n].d), 64'(model_word(v.mode, p % v.w, p / v.w, v.seed, lf)));
            chk($sformatf("sop[%0d]", n), 64'(wq[n].sop), 64'(p == 0));
            chk($sformatf("eop[%0d]", n), 64'(wq[n].eop), 64'(p == area - 1));
            if (consec) chk($sformatf("wr_cycle[%0d]", n), 64'(wq[n].cyc), 64'(s + 2 + n));
            lf = galois(lf);
        end
    endtask

    initial begin
        int   s, a;
        vec_t vx;

        vt[0] = '{4,   2,  1, 1, 32'h0,        0,  8,   8};
        vt[1] = '{0,   5,  1, 1, 32'h0,        0,  0,   0};
        vt[2] = '{3,   0,  2, 2, 32'h0,        0,  0,   0};
        vt[3] = '{5,   3,  2, 0, 32'hA5C3_1E7F, 30, 15,  30};
        vt[4] = '{16,  16, 1, 2, 32'h0,        20, 256, 256};
        vt[5] = '{1,   1,  3, 1, 32'h0,        50, 1,   3};
        vt[6] = '{7,   2,  1, 3, 32'h0,        0,  14,  14};
        vt[7] = '{9,   4,  2, 3, 32'hDEAD_BEEF, 40, 36,  72};
        vt[8] = '{300, 1,  1, 1, 32'h0,        0,  300, 300};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_wrreq", 64'(fifo_wrreq), 64'(0));
        chk("rst_data",  64'(fifo_data),  64'(0));
        chk("rst_sop",   64'(fifo_sop),   64'(0));
        chk("rst_eop",   64'(fifo_eop),   64'(0));
        chk("rst_num",   64'(num_data),   64'(0));
        chk("rst_busy",  64'(busy),       64'(0));
        chk("rst_done",  64'(done),       64'(0));
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cfg(vt[i], 0, 0, 0, s, a);
            verify(vt[i], s, a, vt[i].exp_writes, vt[i].pct == 0);
            if (i == 0 && wq.size() >= 4) begin
                chk("hramp_word0", 64'(wq[0].d), 64'(24'h020100));
                chk("hramp_word3", 64'(wq[3].d), 64'(24'h050403));
            end
            if (i == 6 && wq.size() >= 1) begin
`ifdef IMG_GEN_LFSR_EN
                chk("lfsr_seed0_word0", 64'(wq[0].d), 64'(24'h000001));
`else
                chk("lfsr_off_word0", 64'(wq[0].d), 64'(24'h020100));
`endif
            end
        end

        // Three stalled cycles in the middle of a 4x2 frame.
        run_cfg(vt[0], 3, 3, 0, s, a);
        verify(vt[0], s, a, 8, 1'b0);
        for (int n = 0; n < 8 && n < wq.size(); n++)
            chk($sformatf("stall_wr_cycle[%0d]", n), 64'(wq[n].cyc), 64'(s + stall_cyc[n]));

        // Continuous checker stream aborted after write 300.
        vx = '{16, 16, 0, 2, 32'h0, 0, 256, 0};
        run_cfg(vx, 0, 0, 300, s, a);
        verify(vx, s, a, 300, 1'b1);

        // Reset in the middle of a run, then a fresh run.
        vx = '{8, 8, 1, 1, 32'h0, 0, 64, 64};
        @(posedge clock); #1;
        cfg_width  = 12'd8;
        cfg_height = 12'd8;
        cfg_frames = 16'd1;
        cfg_mode   = 2'd1;
        cfg_seed   = 32'd0;
        start      = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("pre_rst_wrreq", 64'(fifo_wrreq), 64'(1));
        chk("pre_rst_busy",  64'(busy),       64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_wrreq", 64'(fifo_wrreq), 64'(0));
        chk("mid_rst_data",  64'(fifo_data),  64'(0));
        chk("mid_rst_sop",   64'(fifo_sop),   64'(0));
        chk("mid_rst_num",   64'(num_data),   64'(0));
        chk("mid_rst_busy",  64'(busy),       64'(0));
        chk("mid_rst_done",  64'(done),       64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        run_cfg(vx, 0, 0, 0, s, a);
        verify(vx, s, a, 64, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_stream_gen.md
# image_stream_gen

Synthesizable, parametrised successor to the file-driven testbench image source. It generates `CHANNELS`-channel pixel frames internally (constant, ramp, checkerboard and optional LFSR patterns) with no file I/O. It writes the frames into a downstream FIFO through the same write bus (`fifo_full` / `fifo_data` / `fifo_wrreq`), adding frame markers, multi-frame runs and abort. It sits at the head of the vip_core pipeline, both in simulation and in on-chip self-test.

## Interface
- `DWIDTH`, 32, bits per channel
- `CHANNELS`, 3, channels packed per FIFO word
- `DIM_W`, 12, width of the `cfg_width` / `cfg_height` fields
- `clock` input 1: sole clock, rising edge
- `reset` input 1: asynchronous, active-high
- `start` input 1: one-cycle pulse; latches all `cfg_*` inputs
- `abort` input 1: stops generation at the next edge
- `cfg_width` input `DIM_W`: pixels per line
- `cfg_height` input `DIM_W`: lines per frame
- `cfg_frames` input 16: frames per run; 0 means continuous until `abort`
- `cfg_mode` input 2: 0 CONST, 1 HRAMP, 2 CHECKER, 3 LFSR
- `cfg_seed` input 32: constant value for CONST, seed for LFSR
- `fifo_full` input 1: downstream almost-full
- `fifo_data` output `DWIDTH*CHANNELS`: pixel word; channel 0 in the LSBs
- `fifo_wrreq` output 1: write strobe
- `fifo_sop` / `fifo_eop` output 1 each: first / last pixel of a frame, qualified by `fifo_wrreq`
- `num_data` output 32: `cfg_width*cfg_height`, registered at `start`
- `busy` output 1: high in the RUN state
- `done` output 1: one-cycle pulse when a run ends or is aborted

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`, provided width ≠ 0 and height ≠ 0.
  - `start` with width or height = 0: IDLE → DONE with no writes.
  - RUN → DONE after the last pixel of the last frame, or on `abort`.
  - DONE → IDLE unconditionally after one cycle. `done` is high in DONE.
- `start` is ignored while not in IDLE. `cfg_*` are sampled only at `start`, so changes during RUN have no effect.
- Counters `x`, `y` and `frame` each reset to 0 at `start`.
  - `x` wraps at width−1 and then increments `y`.
  - `y` wraps at height−1 and then increments `frame`.
  - When `cfg_frames` = 0, the frame counter wraps modulo 2^16 without ending the run.
- Pixel value for channel `c` (all arithmetic truncated to `DWIDTH`, zero-extended where `DWIDTH` > 32):
  - CONST: `cfg_seed`.
  - HRAMP: `x + c`.
  - CHECKER: all-ones if `x[3] ^ y[3]`, else 0.
  - LFSR: the LFSR state rotated left by 8·c.
- `fifo_sop` is asserted when x=0 and y=0. `fifo_eop` is asserted when x=width−1 and y=height−1.
- `abort` takes priority over a write in the same cycle: that pixel is not written, and `fifo_eop` is not emitted for the truncated frame.
- Reset in any state returns to IDLE. All outputs return to 0.

## Timing
- Reset values: all outputs 0; state IDLE.
- All outputs are registered.
- Write rule: at each edge in RUN, if `fifo_full` = 0, then `fifo_wrreq` = 1 and the counters advance. Otherwise `fifo_wrreq` = 0 and the counters hold.
  - `fifo_full` must therefore give at least 1 entry of slack.
- The first `fifo_wrreq` appears 2 edges after `start` is sampled: one edge to enter RUN, one to register the first pixel.
- Throughput: 1 pixel per clock while `fifo_full` = 0. There is no bubble between lines or frames.
- `done` is high the cycle after the final write, or the cycle after `abort` is sampled.
- `busy` falls in the same cycle that `done` rises.

## Configuration
- `IMG_GEN_LFSR_EN` defined:
  - Mode 3 uses a 32-bit Galois LFSR, polynomial 0x80200003, loaded from `cfg_seed` at `start`. A seed of 0 is replaced by 1.
  - The LFSR advances once per written pixel.
- `IMG_GEN_LFSR_EN` undefined: the LFSR logic is absent, and mode 3 behaves exactly as HRAMP.

## Structure
- Package `img_gen_pkg` holds:
  - the mode encodings;
  - the state encoding;
  - the LFSR polynomial constant `IMG_GEN_LFSR_POLY`.
- Sub-module `img_gen_pattern` is the combinational pixel formatter. Inputs: `x`, `y`, mode, seed, LFSR state. Output: the packed word.
- The top module holds the FSM, counters, LFSR and output registers.

## Test plan
- `start` with width=4, height=2, frames=1, HRAMP, `DWIDTH`=8, `CHANNELS`=3, `fifo_full`=0 → exactly 8 writes on consecutive cycles.
  - Word 0 = 0x020100; word 3 = 0x050403.
  - `fifo_sop` on write 1 only, `fifo_eop` on write 8 only.
  - `num_data`=8; `done` pulses 1 cycle after write 8.
- Same run with `fifo_full` held high for 3 cycles mid-frame → `fifo_wrreq` low for those 3 cycles; no pixel is dropped or duplicated; total is 8 writes.
- width=0 → `done` pulses 1 cycle after `start`; `fifo_wrreq` never asserts.
- frames=0, CHECKER, 16×16 → continuous stream with `fifo_sop` every 256 writes. `abort` after write 300 → no further writes; `done` 1 cycle after `abort`; no `fifo_eop` for the partial frame.
- LFSR mode with seed=0, macro defined → first word = 1 in channel 0, and the sequence matches the reference model. With the macro undefined, the output is identical to HRAMP.
- `reset` asserted mid-RUN → all outputs 0 immediately; a new `start` then produces a fresh frame starting with `fifo_sop`.
